// File: rtl/dsi_pkg.sv
// Shared constants, header record and ECC/CRC helpers for the DSI packet sequencer.
package dsi_pkg;

    localparam logic [7:0]  LEADER_DEF = 8'hB8;
    localparam logic [15:0] CRC_POLY   = 16'h8408;
    localparam logic [15:0] CRC_SEED   = 16'hFFFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEAD = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CRC  = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    typedef struct packed {
        logic [7:0]  di;
        logic [15:0] wc;
        logic        lng;
        logic [7:0]  ecc;
    } dsi_hdr_t;

    // DSI modified Hamming code; d = {wc[15:8], wc[7:0], di}
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [7:0] e;
        e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        e[7:6] = 2'b00;
        return e;
    endfunction

    // Reflected CRC-16 (0x8408), one byte, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[15:1]};
            c  = fb ? (c ^ CRC_POLY) : c;
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Byte-wide CRC-16 accumulator: init reloads the seed, en folds in one byte.
module dsi_crc16
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // CRC register: seed on reset/init, update on enable
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= CRC_SEED;
        end else if (init) begin
            crc <= CRC_SEED;
        end else if (en) begin
            crc <= crc16_byte(crc, data);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/dsi_pkt_seq.sv
// DSI packet sequencer: frames one packet per HS burst (leader, header, ECC,
// payload, CRC) over the transmitter byte handshake, then holds an LP gap.
module dsi_pkt_seq
    import dsi_pkg::*;
#(
    parameter int         GAP_CYCLES = 64,
    parameter logic [7:0] LEADER     = LEADER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [7:0]  pkt_di,
    input  logic [15:0] pkt_wc,
    input  logic        pkt_long,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  d_in,
    output logic        d_req,
    output logic        b_req,
    input  logic        d_ack,
    output logic        busy,
    output logic        underrun,
    input  logic        err_clr
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    logic [2:0]  state_r;
    dsi_hdr_t    hdr_r;
    logic [1:0]  idx_r;
    logic [15:0] cnt_r;
    logic [15:0] gap_r;
    logic [7:0]  d_in_r;
    logic        d_req_r;
    logic        b_req_r;
    logic        busy_r;
    logic        pkt_ready_r;
    logic        pl_ready_r;
    logic        underrun_r;

    logic        accept_s;
    logic        fetch_s;
    logic [7:0]  fetch_byte_s;
    logic [15:0] crc_s;

    assign accept_s     = (state_r == ST_IDLE) && pkt_valid && pkt_ready_r;
    assign fetch_s      = (state_r == ST_PAY) && pl_ready_r;
    assign fetch_byte_s = pl_valid ? pl_data : 8'h00;

    dsi_crc16 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (accept_s),
        .en   (fetch_s),
        .data (fetch_byte_s),
        .crc  (crc_s)
    );

    // Sequencer FSM; d_in always holds the byte for the next transmitter boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hdr_r       <= '0;
            idx_r       <= 2'd0;
            cnt_r       <= 16'd0;
            gap_r       <= 16'd0;
            d_in_r      <= 8'h00;
            d_req_r     <= 1'b0;
            b_req_r     <= 1'b0;
            busy_r      <= 1'b0;
            pkt_ready_r <= 1'b1;
            pl_ready_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        hdr_r.di    <= pkt_di;
                        hdr_r.wc    <= pkt_wc;
                        hdr_r.lng   <= pkt_long;
                        hdr_r.ecc   <= dsi_ecc({pkt_wc, pkt_di});
                        b_req_r     <= 1'b1;
                        d_req_r     <= 1'b1;
                        d_in_r      <= LEADER;
                        busy_r      <= 1'b1;
                        pkt_ready_r <= 1'b0;
                        state_r     <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (d_ack) begin
                        d_in_r  <= hdr_r.di;
                        idx_r   <= 2'd0;
                        state_r <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (d_ack) begin
                        case (idx_r)
                            2'd0: begin
                                d_in_r <= hdr_r.wc[7:0];
                                idx_r  <= 2'd1;
                            end
                            2'd1: begin
                                d_in_r <= hdr_r.wc[15:8];
                                idx_r  <= 2'd2;
                            end
                            2'd2: begin
                                d_in_r <= hdr_r.ecc;
                                idx_r  <= 2'd3;
                            end
                            default: begin
                                if (hdr_r.lng && (hdr_r.wc != 16'd0)) begin
                                    cnt_r      <= hdr_r.wc;
                                    pl_ready_r <= 1'b1;
                                    state_r    <= ST_PAY;
                                end else if (hdr_r.lng) begin
                                    d_in_r  <= crc_s[7:0];
                                    idx_r   <= 2'd0;
                                    state_r <= ST_CRC;
                                end else begin
                                    d_in_r  <= 8'h00;
                                    d_req_r <= 1'b0;
                                    b_req_r <= 1'b0;
                                    gap_r   <= 16'd0;
                                    state_r <= ST_GAP;
                                end
                            end
                        endcase
                    end
                end
                ST_PAY: begin
                    // A fetched byte is already counted, so cnt_r==0 on an ack means the last one went out
                    if (pl_ready_r) begin
                        d_in_r     <= fetch_byte_s;
                        cnt_r      <= cnt_r - 16'd1;
                        pl_ready_r <= 1'b0;
                    end else if (d_ack) begin
                        if (cnt_r == 16'd0) begin
                            d_in_r  <= crc_s[7:0];
                            idx_r   <= 2'd0;
                            state_r <= ST_CRC;
                        end else begin
                            pl_ready_r <= 1'b1;
                        end
                    end
                end
                ST_CRC: begin
                    if (d_ack) begin
                        if (idx_r == 2'd0) begin
                            d_in_r <= crc_s[15:8];
                            idx_r  <= 2'd1;
                        end else begin
                            d_in_r  <= 8'h00;
                            d_req_r <= 1'b0;
                            b_req_r <= 1'b0;
                            gap_r   <= 16'd0;
                            state_r <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_r == GAP_LAST) begin
                        busy_r      <= 1'b0;
                        pkt_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        gap_r <= gap_r + 16'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    d_req_r     <= 1'b0;
                    b_req_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    pkt_ready_r <= 1'b1;
                    pl_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_r <= 1'b0;
        end else if (fetch_s && !pl_valid) begin
            underrun_r <= 1'b1;
        end else if (err_clr) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign pkt_ready = pkt_ready_r;
    assign pl_ready  = pl_ready_r;
    assign d_in      = d_in_r;
    assign d_req     = d_req_r;
    assign b_req     = b_req_r;
    assign busy      = busy_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_dsi_pkt_seq.sv
// Directed bench for dsi_pkt_seq with a behavioural transmitter and payload source.
module tb_dsi_pkt_seq;

    localparam int GAP   = 8;
    localparam int BOUND = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [7:0]  pkt_di = 8'h00;
    logic [15:0] pkt_wc = 16'h0000;
    logic        pkt_long = 1'b0;
    logic [7:0]  pl_data = 8'h00;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [7:0]  d_in;
    logic        d_req;
    logic        b_req;
    logic        d_ack = 1'b0;
    logic        busy;
    logic        underrun;
    logic        err_clr = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay [0:15];
    int         pidx      = 0;
    int         drop_idx  = -1;
    int         pl_pulses = 0;
    bit         take_pend = 1'b0;

    always #5 clk = ~clk;

    dsi_pkt_seq #(.GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_di    (pkt_di),
        .pkt_wc    (pkt_wc),
        .pkt_long  (pkt_long),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .d_in      (d_in),
        .d_req     (d_req),
        .b_req     (b_req),
        .d_ack     (d_ack),
        .busy      (busy),
        .underrun  (underrun),
        .err_clr   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ q[k][b]) c = (c >> 1) ^ 16'h8408;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Transmitter model: latch d_in eight cycles after each load, one-cycle ack
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            d_ack = 1'b0;
            if (d_req && b_req) begin
                wait_cnt++;
                if (wait_cnt == 8) begin
                    rx_q.push_back(d_in);
                    d_ack    = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Payload source: present pay[pidx]; advance after each consumed pl_ready cycle
    initial begin
        forever begin
            @(negedge clk);
            if (take_pend) begin
                pidx++;
                take_pend = 1'b0;
            end
            pl_data  = pay[pidx & 15];
            pl_valid = (pidx != drop_idx);
            if (pl_ready) begin
                pl_pulses++;
                take_pend = 1'b1;
            end
        end
    end

    task automatic finish_burst(input string tag);
        int n;
        n = 0;
        while (b_req && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) chk({tag, "_timeout_breq"}, 32'd0, 32'd1);
        n = 0;
        while (busy && n < BOUND) begin @(negedge clk); n++; end
        chk({tag, "_gap"}, n, GAP);
        chk({tag, "_ready"}, pkt_ready, 1'b1);
        chk({tag, "_dreq"}, d_req, 1'b0);
    endtask

    task automatic run_pkt(input string tag, input logic [7:0] di, input logic [15:0] wc, input logic lng);
        int n;
        rx_q.delete();
        pidx = 0; pl_pulses = 0;
        @(negedge clk);
        pkt_di = di; pkt_wc = wc; pkt_long = lng; pkt_valid = 1'b1;
        n = 0;
        while (!pkt_ready && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) chk({tag, "_timeout_ready"}, 32'd0, 32'd1);
        @(negedge clk);
        pkt_valid = 1'b0;
        chk({tag, "_lead"}, d_in, 8'hB8);
        chk({tag, "_breq_hi"}, {busy, b_req, d_req, pkt_ready}, 4'b1110);
        finish_burst(tag);
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;
        logic [15:0] c;
        logic [7:0]  sent[$];
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'h31 + i);

        repeat (3) @(negedge clk);
        chk("rst_outs", {pkt_ready, pl_ready, d_req, b_req, busy, underrun}, 6'b100000);
        chk("rst_din", d_in, 8'h00);
        rst = 1'b0;

        run_pkt("short11", 8'h05, 16'h0011, 1'b0);
        exp_q = '{8'hB8, 8'h05, 8'h11, 8'h00, 8'h36};
        check_bytes("short11");

        run_pkt("short29", 8'h05, 16'h0029, 1'b0);
        exp_q = '{8'hB8, 8'h05, 8'h29, 8'h00, 8'h1C};
        check_bytes("short29");

        run_pkt("long9", 8'h39, 16'h0009, 1'b1);
        exp_q = '{8'hB8, 8'h39, 8'h09, 8'h00, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                  8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
        check_bytes("long9");
        chk("long9_pulses", pl_pulses, 9);
        chk("long9_no_underrun", underrun, 1'b0);

        run_pkt("long0", 8'h29, 16'h0000, 1'b1);
        exp_q = '{8'hB8, 8'h29, 8'h00, 8'h00, 8'h1C, 8'hFF, 8'hFF};
        check_bytes("long0");
        chk("long0_pulses", pl_pulses, 0);

        drop_idx = 2;
        run_pkt("undr", 8'h39, 16'h0004, 1'b1);
        drop_idx = -1;
        sent = '{8'h31, 8'h32, 8'h00, 8'h34};
        c = crc_ref(sent);
        exp_q = '{8'hB8, 8'h39, 8'h04, 8'h00, 8'h2C, 8'h31, 8'h32, 8'h00, 8'h34};
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
        check_bytes("undr");
        chk("undr_flag", underrun, 1'b1);
        repeat (5) @(negedge clk);
        chk("undr_sticky", underrun, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("undr_clr", underrun, 1'b0);

        // Back-to-back with pkt_valid held high
        rx_q.delete();
        pkt_di = 8'h05; pkt_wc = 16'h0011; pkt_long = 1'b0; pkt_valid = 1'b1;
        n = 0;
        while (!b_req && n < BOUND) begin @(negedge clk); n++; end
        while (b_req && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) chk("b2b_timeout", 32'd0, 32'd1);
        n = 0;
        while (!pkt_ready && n < BOUND) begin @(negedge clk); n++; end
        chk("b2b_gap_min", (n >= GAP), 1'b1);
        @(negedge clk);
        pkt_valid = 1'b0;
        chk("b2b_second_breq", b_req, 1'b1);
        finish_burst("b2b");
        chk("b2b_nbytes", rx_q.size(), 10);
        if (rx_q.size() == 10) chk("b2b_lead2", rx_q[5], 8'hB8);

        // Reset in the middle of the payload
        pidx = 0; pl_pulses = 0;
        @(negedge clk);
        pkt_di = 8'h39; pkt_wc = 16'h0009; pkt_long = 1'b1; pkt_valid = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        n = 0;
        while (pl_pulses < 3 && n < BOUND) begin @(negedge clk); n++; end
        if (n >= BOUND) chk("rstpay_timeout", 32'd0, 32'd1);
        chk("rstpay_in_burst", b_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstpay_outs", {pkt_ready, pl_ready, d_req, b_req, busy}, 5'b10000);
        chk("rstpay_din", d_in, 8'h00);
        repeat (20) @(negedge clk);
        chk("rstpay_idle", {pkt_ready, b_req, busy}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
